// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, read ports and busy flag.
// master = register-file client, slave = regfile_mp.
interface regfile_mp_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 5,
  parameter int NUM_READ    = 2,
  parameter int NUM_WRITE   = 2
);
  logic [NUM_WRITE-1:0]                  write_en;
  logic [NUM_WRITE-1:0][ADDR_LENGTH-1:0] write_addr;
  logic [NUM_WRITE-1:0][WORD_LENGTH-1:0] data;
  logic [NUM_READ-1:0][ADDR_LENGTH-1:0]  read_addr;
  logic [NUM_READ-1:0][WORD_LENGTH-1:0]  read_data;
  logic                                  busy;

  modport master (
    output write_en,
    output write_addr,
    output data,
    output read_addr,
    input  read_data,
    input  busy
  );

  modport slave (
    input  write_en,
    input  write_addr,
    input  data,
    input  read_addr,
    output read_data,
    output busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with a clear sweep after reset; x0 reads 0.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 5,
  parameter int NUM_REGS    = 32,
  parameter int NUM_READ    = 2,
  parameter int NUM_WRITE   = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int LP_IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_LENGTH:0] LP_NREGS =
    (ADDR_LENGTH+1)'(NUM_REGS);
  localparam logic [LP_IW-1:0] LP_LAST = LP_IW'(NUM_REGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LP_IW-1:0]       r_idx;
  logic [LP_IW-1:0]       w_idx_nxt;
  logic                   w_busy;
  logic [WORD_LENGTH-1:0] r_regs [NUM_REGS];

  logic [NUM_WRITE-1:0]             w_wr_ok;
  logic [NUM_WRITE-1:0][LP_IW-1:0]  w_wr_row;
  logic [NUM_READ-1:0]              w_rd_ok;
  logic [NUM_READ-1:0][LP_IW-1:0]   w_rd_row;
  logic [NUM_READ-1:0][WORD_LENGTH-1:0] w_rdata;

  // Address 0 is hardwired and addresses past NUM_REGS do not exist.
  function automatic logic addr_ok(
    input logic [ADDR_LENGTH-1:0] a
  );
    return (a != '0) && ({1'b0, a} < LP_NREGS);
  endfunction

  // Decode every write and read address to a legal row index.
  always_comb begin
    for (int w = 0; w < NUM_WRITE; w++) begin
      w_wr_ok[w]  = addr_ok(bus.write_addr[w]);
      w_wr_row[w] = bus.write_addr[w][LP_IW-1:0];
    end
    for (int r = 0; r < NUM_READ; r++) begin
      w_rd_ok[r]  = addr_ok(bus.read_addr[r]);
      w_rd_row[r] = bus.read_addr[r][LP_IW-1:0];
    end
  end

  // Sweep state register; reset restarts the sweep at row 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic: step through every row, then go ready.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_busy      = 1'b0;
    unique case (r_state)
      CLEAR: begin
        w_busy = 1'b1;
        if (r_idx == LP_LAST) begin
          w_state_nxt = READY;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      READY: begin
        w_state_nxt = READY;
      end
      default: begin
        w_state_nxt = CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Storage: zero one row per sweep cycle, else apply writes
  // in port order so the highest-numbered port wins a collision.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_regs[r_idx] <= '0;
    end else if (!rst) begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (bus.write_en[w] && w_wr_ok[w]) begin
          r_regs[w_wr_row[w]] <= bus.data[w];
        end
      end
    end
  end

  // Combinational read ports; zero while sweeping or for bad rows.
  always_comb begin
    for (int r = 0; r < NUM_READ; r++) begin
      w_rdata[r] = '0;
      if (r_state == READY && w_rd_ok[r]) begin
        w_rdata[r] = r_regs[w_rd_row[r]];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (bus.write_en[w] && w_wr_ok[w] &&
              bus.write_addr[w] == bus.read_addr[r]) begin
            w_rdata[r] = bus.data[w];
          end
        end
`endif
      end
    end
  end

  assign bus.read_data = w_rdata;
  assign bus.busy      = w_busy;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_LENGTH, default 5: register address width.
REQ-003 SHALL have parameter NUM_REGS, default 32: number of registers, 2..2**ADDR_LENGTH.
REQ-004 SHALL have parameter NUM_READ, default 2: number of read ports, 1..4.
REQ-005 SHALL have parameter NUM_WRITE, default 2: number of write ports, 1..2.
REQ-006 SHALL have port clk, input, 1: single clock, all state updates on posedge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port write_en, input, [NUM_WRITE]: per-port write enable.
REQ-009 SHALL have port write_addr, input, [NUM_WRITE][ADDR_LENGTH]: per-port write address.
REQ-010 SHALL have port data, input, [NUM_WRITE][WORD_LENGTH]: per-port write data.
REQ-011 SHALL have port read_addr, input, [NUM_READ][ADDR_LENGTH]: per-port read address.
REQ-012 SHALL have port read_data, output, [NUM_READ][WORD_LENGTH]: per-port read data, combinational.
REQ-013 SHALL have port busy, output, 1: high while the clear sweep runs.

Function
REQ-014 SHALL implement a two-state FSM with states CLEAR (busy=1) and READY (busy=0).
REQ-015 In CLEAR, each cycle SHALL write zero to regs[idx] and increment idx; when idx==NUM_REGS-1, SHALL go to READY next cycle (sweep = NUM_REGS cycles).
REQ-016 In CLEAR, all write_en inputs SHALL be ignored, and every read_data SHALL be 0.
REQ-017 In READY, SHALL write data[w] to regs[write_addr[w]] at posedge when write_en[w]=1.
REQ-018 SHALL discard writes to address 0; a read of address 0 SHALL return 0.
REQ-019 SHALL discard writes to address >= NUM_REGS; such reads SHALL return 0.
REQ-020 When both ports write the same address in one cycle, port 1 SHALL win.
REQ-021 Without bypass, a read SHALL return the value stored before the current posedge (write visible the cycle after).
REQ-022 Reads on all ports SHALL be independent; identical addresses on several ports SHALL return identical data.

Reset
REQ-023 rst=1 at posedge SHALL force CLEAR with idx=0; busy SHALL be 1 in the cycle after that posedge.
REQ-024 While rst stays high, idx SHALL hold at 0; the sweep SHALL start on the first posedge with rst=0.
REQ-025 rst asserted mid-sweep or in READY SHALL restart the sweep at idx=0; partial contents SHALL NOT be relied upon.
REQ-026 After reset completes, all registers SHALL read 0 and busy SHALL be 0.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL compile in write-to-read forwarding.
REQ-028 With REGFILE_BYPASS_EN defined, in READY, read_data[r] SHALL equal data[w] in the same cycle when write_en[w]=1 and write_addr[w]==read_addr[r]!=0 (<NUM_REGS), with port 1 priority.
REQ-029 Without REGFILE_BYPASS_EN, no forwarding logic SHALL exist and REQ-021 SHALL apply.

Verification
REQ-030 rst high 3 cycles then low -> busy=1 for exactly 32 cycles, then 0; all 32 registers read 0.
REQ-031 READY, port0 writes 0xDEADBEEF to x5 -> read_addr0=5 returns 0xDEADBEEF next cycle (same cycle if REGFILE_BYPASS_EN).
REQ-032 Both ports write x7 (port0 0x11111111, port1 0x22222222) -> x7 reads 0x22222222.
REQ-033 Write 0xFFFFFFFF to x0 -> x0 reads 0 on all read ports, in the same and following cycles.
REQ-034 rst pulsed at sweep cycle 10, then write attempted during busy -> sweep restarts (32 more busy cycles) and the write is dropped.
REQ-035 NUM_REGS=16, write to address 20 -> no register changes; read of 20 returns 0.
